// File: rtl/wb_crc32_pkg.sv
// Shared CRC-32 constants, FSM state type and the bytewise reflected CRC step
// used by the Wishbone CRC reader.
package wb_crc32_pkg;

  localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    DONE
  } state_t;

  // Reflected CRC-32 over one byte, bit 0 of the byte shifted in first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone B4 bundle (32-bit data, byte selects, stall).
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        err;
  logic        stall;

  modport master (
    output cyc, stb, we, sel, adr, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_m,
    output dat_s, ack, err, stall
  );
endinterface

// File: rtl/crc32_word_step.sv
// Combinational CRC-32 update for one 32-bit word, least significant byte first.
module crc32_word_step
  import wb_crc32_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_b0;
  logic [31:0] crc_b1;
  logic [31:0] crc_b2;

  assign crc_b0  = crc32_byte(crc_in, data[7:0]);
  assign crc_b1  = crc32_byte(crc_b0, data[15:8]);
  assign crc_b2  = crc32_byte(crc_b1, data[23:16]);
  assign crc_out = crc32_byte(crc_b2, data[31:24]);

endmodule

// File: rtl/wb_crc32_reader.sv
// Pipelined Wishbone read initiator folding a word-aligned RAM window into a CRC-32.
// Optional CRC32_EXPECT_CHECK_EN adds expect_crc input and match output.
module wb_crc32_reader
  import wb_crc32_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_if.master             wb,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len_words,
`ifdef CRC32_EXPECT_CHECK_EN
  input  logic [31:0]      expect_crc,
  output logic             match,
`endif
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      crc
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      adr;
  logic [LEN_W-1:0] remaining;
  logic [3:0]       outstanding;
  logic [31:0]      crc_acc;
  logic [31:0]      crc_step;
  logic             cyc;
  logic             stb;
  logic             issue;
  logic             resp;
  logic             resp_ack;
  logic             resp_err;
  logic             unused_addr_bits;

`ifdef CRC32_EXPECT_CHECK_EN
  logic [31:0]      expect_q;
`endif

  assign unused_addr_bits = ^base_addr[1:0];

  assign cyc      = (state == REQ) || (state == DRAIN);
  assign stb      = (state == REQ) && (remaining != '0) && (outstanding < MAX_OUT_C);
  assign issue    = stb && !wb.stall;
  // Responses beyond the issued count are ignored so the counter cannot underflow.
  assign resp     = cyc && (wb.ack || wb.err) && (outstanding != 4'd0);
  assign resp_err = resp && wb.err;
  assign resp_ack = resp && !wb.err;

  assign wb.cyc   = cyc;
  assign wb.stb   = stb;
  assign wb.we    = 1'b0;
  assign wb.sel   = 4'hF;
  assign wb.adr   = adr;
  assign wb.dat_m = 32'h0;

  crc32_word_step u_step (
    .crc_in  (crc_acc),
    .data    (wb.dat_s),
    .crc_out (crc_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len_words != '0) ? REQ : DONE;
      REQ:     if (resp_err || (remaining == '0)) state_nxt = DRAIN;
      DRAIN:   if (outstanding == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr         <= 32'h0;
      remaining   <= '0;
      outstanding <= 4'd0;
      crc_acc     <= CRC_INIT;
      crc         <= 32'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
`ifdef CRC32_EXPECT_CHECK_EN
      expect_q    <= 32'h0;
      match       <= 1'b0;
`endif
    end else begin
      done <= (state_nxt == DONE);

      case ({issue, resp})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
`ifdef CRC32_EXPECT_CHECK_EN
            expect_q <= expect_crc;
`endif
            if (len_words != '0) begin
              adr       <= {base_addr[31:2], 2'b00};
              remaining <= len_words;
              crc_acc   <= CRC_INIT;
              busy      <= 1'b1;
            end else begin
              crc <= 32'h0;
`ifdef CRC32_EXPECT_CHECK_EN
              match <= (expect_crc == 32'h0);
`endif
            end
          end
        end
        REQ, DRAIN: begin
          if (issue) begin
            adr       <= adr + 32'd4;
            remaining <= remaining - LEN_W'(1);
          end
          // An error stops further issue; words still in flight are drained but not folded.
          if (resp_err) begin
            error     <= 1'b1;
            remaining <= '0;
          end
          if (resp_ack && !error) begin
            crc_acc <= crc_step;
          end
          if (state_nxt == DONE) begin
            crc  <= crc_acc ^ CRC_XOROUT;
            busy <= 1'b0;
`ifdef CRC32_EXPECT_CHECK_EN
            match <= ((crc_acc ^ CRC_XOROUT) == expect_q) && !error;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_crc32_reader.sv
// Self-checking bench for wb_crc32_reader: pipelined RAM slave with stall/latency/err
// injection and a bit-serial CRC-32 reference model.
module tb_wb_crc32_reader;

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          is_err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] len_words;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] crc;
`ifdef CRC32_EXPECT_CHECK_EN
  logic [31:0] expect_crc;
  logic        match;
`endif

  wb_if wbif();

  always #5 clk = ~clk;

  wb_crc32_reader #(
    .MAX_OUT (4),
    .LEN_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wbif),
    .start      (start),
    .base_addr  (base_addr),
    .len_words  (len_words),
`ifdef CRC32_EXPECT_CHECK_EN
    .expect_crc (expect_crc),
    .match      (match),
`endif
    .busy       (busy),
    .done       (done),
    .error      (error),
    .crc        (crc)
  );

  logic [31:0] ram [0:255];
  rsp_t        rq[$];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc_cnt = 0;
  int          stall_mode = 0;
  int          lat_fixed  = 1;
  int          err_at     = -1;
  int          issued_cnt, ack_cnt, done_cnt, out_model, max_out;
  int          proto_viol, adr_viol, stb_after_err;
  bit          err_sent, saw_cyc, prev_stalled;
  logic [31:0] prev_adr, exp_adr;
  logic [31:0] got_crc;
  logic        got_err, busy_start, busy_done, timed_out;
  int          lat_cycles;

  // Pipelined RAM slave and bus protocol monitor, all on the falling edge.
  always @(negedge clk) begin : slave
    rsp_t r;
    int   lat;
    cyc_cnt++;
    if (!rst_n) begin
      rq.delete();
      out_model    = 0;
      wbif.ack     = 1'b0;
      wbif.err     = 1'b0;
      wbif.stall   = 1'b0;
      wbif.dat_s   = 32'h0;
      prev_stalled = 1'b0;
    end else begin
      if (wbif.cyc) saw_cyc = 1'b1;
      if (wbif.stb && !wbif.cyc) proto_viol++;
      if (wbif.we !== 1'b0 || wbif.sel !== 4'hF || wbif.dat_m !== 32'h0) proto_viol++;
      if (!wbif.cyc && out_model != 0) proto_viol++;
      if (err_sent && wbif.stb) stb_after_err++;
      if (prev_stalled && !err_sent && (!wbif.stb || wbif.adr !== prev_adr)) proto_viol++;
      if (done) done_cnt++;

      wbif.ack   = 1'b0;
      wbif.err   = 1'b0;
      wbif.dat_s = $urandom;
      if (rq.size() > 0 && rq[0].due <= cyc_cnt) begin
        r = rq.pop_front();
        out_model--;
        wbif.dat_s = r.data;
        if (r.is_err) begin
          wbif.err = 1'b1;
          err_sent = 1'b1;
        end else begin
          wbif.ack = 1'b1;
          ack_cnt++;
        end
      end

      case (stall_mode)
        0:       wbif.stall = 1'b0;
        1:       wbif.stall = cyc_cnt[0];
        default: wbif.stall = 1'($urandom_range(0, 1));
      endcase

      if (wbif.cyc && wbif.stb && !wbif.stall) begin
        lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
        if (wbif.adr !== exp_adr) adr_viol++;
        r.due    = cyc_cnt + lat;
        r.data   = ram[wbif.adr[9:2]];
        r.is_err = (issued_cnt == err_at);
        rq.push_back(r);
        issued_cnt++;
        out_model++;
        exp_adr = exp_adr + 32'd4;
        if (out_model > max_out) max_out = out_model;
      end
      prev_stalled = wbif.cyc && wbif.stb && wbif.stall;
      prev_adr     = wbif.adr;
    end
  end

  // Reference CRC: the window as one bit stream, bit 0 of each word first.
  function automatic logic [31:0] ref_crc(input logic [31:0] base, input int n);
    logic [31:0] c;
    logic [31:0] a;
    logic [31:0] w;
    c = 32'hFFFFFFFF;
    a = base & 32'hFFFFFFFC;
    for (int k = 0; k < n; k++) begin
      w = ram[a[9:2]];
      for (int b = 0; b < 32; b++) begin
        c = (c >> 1) ^ (((c[0] ^ w[b]) != 1'b0) ? 32'hEDB88320 : 32'h0);
      end
      a = a + 32'd4;
    end
    return ~c;
  endfunction

  task automatic clear_stats(input logic [31:0] base);
    issued_cnt    = 0;
    ack_cnt       = 0;
    done_cnt      = 0;
    err_sent      = 1'b0;
    stb_after_err = 0;
    proto_viol    = 0;
    adr_viol      = 0;
    max_out       = 0;
    saw_cyc       = 1'b0;
    exp_adr       = base & 32'hFFFFFFFC;
  endtask

  task automatic run_burst(input logic [31:0] base, input int len, input int extra_at);
    clear_stats(base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    len_words = len[15:0];
    @(negedge clk);
    start      = 1'b0;
    busy_start = busy;
    lat_cycles = 0;
    timed_out  = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (i == extra_at) begin
        start     = 1'b1;
        base_addr = 32'h200;
        len_words = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat_cycles++;
    end
    start     = 1'b0;
    got_crc   = crc;
    got_err   = error;
    busy_done = busy;
    repeat (3) @(negedge clk);
    n_tests++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required done=1", done, lat_cycles);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (wbif.cyc !== 1'b0 || wbif.stb !== 1'b0 || wbif.we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b, required 0 0 0", wbif.cyc, wbif.stb, wbif.we);
    end
    n_tests++;
    if (wbif.sel !== 4'hF || wbif.adr !== 32'h0 || wbif.dat_m !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drive: sel=%h adr=%h dat_m=%h, required F 0 0", wbif.sel, wbif.adr, wbif.dat_m);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || crc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b error=%b crc=%h, required 0 0 0 0", busy, done, error, crc);
    end
  endtask

  task automatic test_single_word();
    ram[0] = 32'h0;
    stall_mode = 0; lat_fixed = 1; err_at = -1;
    run_burst(32'h0, 1, -1);
    n_tests++;
    if (got_crc !== 32'h2144DF1C) begin
      n_fail++;
      $display("FAIL single_crc: got %h, required 2144df1c", got_crc);
    end
    n_tests++;
    if (got_err !== 1'b0 || done_cnt != 1 || issued_cnt != 1 || busy_start !== 1'b1 || busy_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ctrl: err=%b dones=%0d reads=%0d busy_start=%b busy_done=%b, required 0 1 1 1 0",
               got_err, done_cnt, issued_cnt, busy_start, busy_done);
    end
    run_burst(32'h3, 1, -1);
    n_tests++;
    if (got_crc !== 32'h2144DF1C || adr_viol != 0) begin
      n_fail++;
      $display("FAIL unaligned_base: crc=%h adr_errs=%0d, required 2144df1c 0", got_crc, adr_viol);
    end
  endtask

  task automatic test_known_string();
    ram[0] = 32'h34333231;
    ram[1] = 32'h38373635;
    run_burst(32'h0, 2, -1);
    n_tests++;
    if (got_crc !== 32'h9AE0DAAF || ack_cnt != 2) begin
      n_fail++;
      $display("FAIL string_crc: crc=%h acks=%0d, required 9ae0daaf 2", got_crc, ack_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_burst(32'h40, 0, -1);
    n_tests++;
    if (got_crc !== 32'h0 || saw_cyc || issued_cnt != 0) begin
      n_fail++;
      $display("FAIL zero_len_bus: crc=%h saw_cyc=%b reads=%0d, required 0 0 0", got_crc, saw_cyc, issued_cnt);
    end
    n_tests++;
    if (lat_cycles != 0 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_len_done: latency=%0d dones=%0d, required 0 1", lat_cycles, done_cnt);
    end
  endtask

  task automatic test_stall_burst();
    logic [31:0] exp;
    for (int i = 16; i < 32; i++) ram[i] = $urandom;
    stall_mode = 1; lat_fixed = 3;
    exp = ref_crc(32'h40, 16);
    run_burst(32'h40, 16, -1);
    n_tests++;
    if (got_crc !== exp) begin
      n_fail++;
      $display("FAIL stall_crc: got %h, required %h", got_crc, exp);
    end
    n_tests++;
    if (ack_cnt != 16 || max_out > 4 || proto_viol != 0 || adr_viol != 0) begin
      n_fail++;
      $display("FAIL stall_bus: acks=%0d max_out=%0d proto=%0d adr=%0d, required 16 <=4 0 0",
               ack_cnt, max_out, proto_viol, adr_viol);
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    logic [31:0] exp;
    int          len;
    for (int it = 0; it < 6; it++) begin
      base       = $urandom;
      len        = int'($urandom_range(1, 40));
      stall_mode = int'($urandom_range(0, 2));
      lat_fixed  = int'($urandom_range(0, 4));
      exp        = ref_crc(base, len);
      run_burst(base, len, -1);
      n_tests++;
      if (got_crc !== exp || ack_cnt != len || max_out > 4 || proto_viol != 0 || adr_viol != 0) begin
        n_fail++;
        $display("FAIL random_%0d: crc=%h (req %h) acks=%0d (req %0d) max_out=%0d proto=%0d adr=%0d",
                 it, got_crc, exp, ack_cnt, len, max_out, proto_viol, adr_viol);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    stall_mode = 2; lat_fixed = 0;
    exp = ref_crc(32'hFFFFFFF8, 4);
    run_burst(32'hFFFFFFF8, 4, -1);
    n_tests++;
    if (got_crc !== exp || got_err !== 1'b0 || adr_viol != 0) begin
      n_fail++;
      $display("FAIL addr_wrap: crc=%h (req %h) err=%b adr_errs=%0d", got_crc, exp, got_err, adr_viol);
    end
  endtask

  task automatic test_error();
    stall_mode = 0; lat_fixed = 2; err_at = 2;
    run_burst(32'h100, 8, -1);
    err_at = -1;
    n_tests++;
    if (got_err !== 1'b1 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL err_status: error=%b dones=%0d, required 1 1", got_err, done_cnt);
    end
    n_tests++;
    if (stb_after_err != 0 || proto_viol != 0 || issued_cnt >= 8) begin
      n_fail++;
      $display("FAIL err_bus: stb_after_err=%0d proto=%0d reads=%0d, required 0 0 <8",
               stb_after_err, proto_viol, issued_cnt);
    end
    ram[0] = 32'h0;
    run_burst(32'h0, 1, -1);
    n_tests++;
    if (got_err !== 1'b0 || got_crc !== 32'h2144DF1C) begin
      n_fail++;
      $display("FAIL err_clear: error=%b crc=%h, required 0 2144df1c", got_err, got_crc);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] exp;
    stall_mode = 1; lat_fixed = 3;
    exp = ref_crc(32'h100, 6);
    run_burst(32'h100, 6, 2);
    n_tests++;
    if (got_crc !== exp || issued_cnt != 6 || done_cnt != 1 || adr_viol != 0) begin
      n_fail++;
      $display("FAIL busy_start: crc=%h (req %h) reads=%0d dones=%0d adr_errs=%0d, required 6 1 0",
               got_crc, exp, issued_cnt, done_cnt, adr_viol);
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] exp;
    int          waited;
    stall_mode = 0; lat_fixed = 4;
    clear_stats(32'h300);
    @(negedge clk);
    start = 1'b1; base_addr = 32'h300; len_words = 16'd8;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (out_model < 2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (out_model < 2) begin
      n_fail++;
      $display("FAIL midreset_setup: outstanding=%0d, required >=2", out_model);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (wbif.cyc !== 1'b0 || wbif.stb !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: cyc=%b stb=%b busy=%b, required 0 0 0", wbif.cyc, wbif.stb, busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lat_fixed = 1;
    exp = ref_crc(32'h80, 1);
    run_burst(32'h80, 1, -1);
    n_tests++;
    if (got_crc !== exp || done_cnt != 1 || proto_viol != 0) begin
      n_fail++;
      $display("FAIL midreset_recover: crc=%h (req %h) dones=%0d proto=%0d", got_crc, exp, done_cnt, proto_viol);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 32'h0;
    len_words = 16'd0;
`ifdef CRC32_EXPECT_CHECK_EN
    expect_crc = 32'h0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_known_string();
    test_zero_len();
    test_stall_burst();
    test_random();
    test_wrap();
    test_error();
    test_start_while_busy();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
